// File: rtl/password_pkg.sv
// password_pkg: shared widths, default password codes and programmer state type.
package password_pkg;
  localparam int CODE_W = 5;
  localparam int N_SLOTS = 4;
  localparam int SLOT_W = 2;
  localparam logic [CODE_W-1:0] DEF_CODE0 = 5'b11001;
  localparam logic [CODE_W-1:0] DEF_CODE1 = 5'b10111;
  localparam logic [CODE_W-1:0] DEF_CODE2 = 5'b01010;
  localparam logic [CODE_W-1:0] DEF_CODE3 = 5'b11100;
  typedef enum logic [2:0] {IDLE, NEW1, NEW2, COMMIT, DONE, ERR} state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/password_programmer_if.sv
// password_programmer_if: front-end inputs and table/status outputs of the enrolment block.
interface password_programmer_if;
  import password_pkg::*;
  logic [CODE_W-1:0] code_in;
  logic [SLOT_W-1:0] slot_sel;
  logic enter;
  logic prog_en;
  logic [CODE_W*N_SLOTS-1:0] tbl_flat;
  logic busy;
  logic done_led;
  logic err_led;
  modport master(output code_in, slot_sel, enter, prog_en, input tbl_flat, busy, done_led, err_led);
  modport slave(input code_in, slot_sel, enter, prog_en, output tbl_flat, busy, done_led, err_led);
endinterface

// File: rtl/pw_hold_timer.sv
// pw_hold_timer: loadable down-counter that saturates at zero and flags expiry.
module pw_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/password_programmer.sv
// password_programmer: authenticate / new / confirm enrolment of one slot of the password table.
// Optional PWPROG_DUP_CHECK_EN rejects a new code already held by another slot.
module password_programmer
  import password_pkg::*;
#(
  parameter int TIMEOUT_CYC = 250_000_000,
  parameter int HOLD_CYC = 100_000_000
) (
  input logic clk,
  input logic rst_n,
  password_programmer_if.slave bus
);
  localparam int CNT_W = $clog2(max2(max2(TIMEOUT_CYC, HOLD_CYC), 2));
  state_t state, nxt;
  logic [SLOT_W-1:0] slot_q;
  logic [CODE_W-1:0] new_q;
  logic [N_SLOTS-1:0][CODE_W-1:0] tbl;
  logic expired, auth_ok, dup;
  assign auth_ok = bus.code_in == tbl[bus.slot_sel];
  assign bus.tbl_flat = tbl;
`ifdef PWPROG_DUP_CHECK_EN
  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < N_SLOTS; k++)
      if (SLOT_W'(k) != slot_q && tbl[k] == new_q) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif
  // dropping prog_en outranks enter and timeout in every non-idle state
  always_comb begin
    nxt = state;
    if (state != IDLE && !bus.prog_en) nxt = IDLE;
    else
      case (state)
        IDLE:    if (bus.enter && bus.prog_en) nxt = auth_ok ? NEW1 : ERR;
        NEW1:    nxt = bus.enter ? NEW2 : expired ? ERR : NEW1;
        NEW2:    nxt = bus.enter ? ((bus.code_in == new_q && !dup) ? COMMIT : ERR) : expired ? ERR : NEW2;
        COMMIT:  nxt = DONE;
        default: nxt = expired ? IDLE : state;
      endcase
  end
  // every transition reloads the timer: timeout budget for NEW1/NEW2, hold time otherwise
  pw_hold_timer #(.W(CNT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(nxt != state),
    .load_val((nxt == NEW1 || nxt == NEW2) ? CNT_W'(TIMEOUT_CYC - 1) : CNT_W'(HOLD_CYC - 1)),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      slot_q <= '0;
      new_q <= '0;
      tbl <= {DEF_CODE3, DEF_CODE2, DEF_CODE1, DEF_CODE0};
      bus.busy <= 1'b0;
      bus.done_led <= 1'b0;
      bus.err_led <= 1'b0;
    end else begin
      state <= nxt;
      bus.busy <= nxt != IDLE;
      bus.done_led <= nxt == DONE;
      bus.err_led <= nxt == ERR;
      if (state == IDLE && nxt != IDLE) slot_q <= bus.slot_sel;
      if (state == NEW1 && nxt == NEW2) new_q <= bus.code_in;
      else if (nxt == IDLE) new_q <= '0;
      if (state == COMMIT && nxt == DONE) tbl[slot_q] <= new_q;
    end
endmodule

// File: tb/tb_password_programmer.sv
// tb_password_programmer: directed enrolment scenarios checked against a phase/age reference model.
module tb_password_programmer;
  localparam int T = 12;
  localparam int H = 6;
  logic clk = 0;
  logic rst_n = 0;
  int n_tests = 0;
  int n_fail = 0;
  password_programmer_if bus();
  password_programmer #(.TIMEOUT_CYC(T), .HOLD_CYC(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // reference: phase 0 idle,1 new1,2 new2,3 commit,4 done,5 err; age = cycles since entry/last enter
  int ph, age, m_slot;
  logic [4:0] m_tbl [4];
  logic [4:0] m_new;
  function automatic logic model_dup();
    logic d = 1'b0;
`ifdef PWPROG_DUP_CHECK_EN
    for (int i = 0; i < 4; i++) if (i != m_slot && m_tbl[i] == m_new) d = 1'b1;
`endif
    return d;
  endfunction
  task automatic go(input int p);
    ph = p;
    age = 0;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tbl[0] = 5'b11001; m_tbl[1] = 5'b10111; m_tbl[2] = 5'b01010; m_tbl[3] = 5'b11100;
      go(0); m_slot = 0; m_new = 0;
    end else if (ph != 0 && !bus.prog_en) go(0);
    else if (ph == 0) begin
      if (bus.enter && bus.prog_en) begin
        m_slot = int'(bus.slot_sel);
        go(bus.code_in == m_tbl[m_slot] ? 1 : 5);
      end
    end else if (ph == 1 || ph == 2) begin
      if (bus.enter) begin
        if (ph == 1) begin m_new = bus.code_in; go(2); end
        else go((bus.code_in == m_new && !model_dup()) ? 3 : 5);
      end else begin
        age++;
        if (age == T) go(5);
      end
    end else if (ph == 3) begin
      m_tbl[m_slot] = m_new;
      go(4);
    end else begin
      age++;
      if (age == H) go(0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("model_busy", 32'(bus.busy), 32'(ph != 0));
    chk("model_done", 32'(bus.done_led), 32'(ph == 4));
    chk("model_err", 32'(bus.err_led), 32'(ph == 5));
    chk("model_tbl", 32'(bus.tbl_flat), 32'({m_tbl[3], m_tbl[2], m_tbl[1], m_tbl[0]}));
  end

  task automatic pulse(input logic [4:0] c, input logic [1:0] s);
    @(negedge clk);
    bus.code_in = c;
    bus.slot_sel = s;
    bus.enter = 1;
    @(negedge clk);
    bus.enter = 0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    bus.code_in = 0; bus.slot_sel = 0; bus.enter = 0; bus.prog_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset_tbl", 32'(bus.tbl_flat), 32'(20'b11100_01010_10111_11001));
    chk("reset_busy", 32'(bus.busy), 0);
    // enter without prog_en is ignored
    pulse(5'b11001, 0);
    chk("noprog_busy", 32'(bus.busy), 0);
    bus.prog_en = 1;
    // happy path on slot 2
    pulse(5'b01010, 2);
    chk("auth_new1", 32'({bus.busy, bus.err_led}), 32'b10);
    pulse(5'b00111, 0);
    pulse(5'b00111, 0);
    chk("commit_cycle", 32'({bus.busy, bus.done_led, bus.err_led}), 32'b100);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done_led) n++;
      else if (n > 0) break;
    end
    chk("done_hold_len", 32'(n), 32'(H));
    chk("happy_idle", 32'(bus.busy), 0);
    chk("happy_slot2", 32'(bus.tbl_flat[14:10]), 32'(5'b00111));
    // bad authentication
    pulse(5'b00000, 0);
    chk("badauth_err", 32'(bus.err_led), 1);
    wait_idle("badauth");
    chk("badauth_tbl", 32'(bus.tbl_flat), 32'(20'b11100_00111_10111_11001));
    // confirm mismatch
    pulse(5'b10111, 1);
    pulse(5'b00001, 0);
    pulse(5'b00010, 0);
    chk("mismatch_err", 32'(bus.err_led), 1);
    wait_idle("mismatch");
    chk("mismatch_slot1", 32'(bus.tbl_flat[9:5]), 32'(5'b10111));
    // prog_en dropped in NEW2
    pulse(5'b11100, 3);
    pulse(5'b00011, 0);
    bus.prog_en = 0;
    @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_slot3", 32'(bus.tbl_flat[19:15]), 32'(5'b11100));
    bus.prog_en = 1;
    // timeout in NEW1
    pulse(5'b11001, 0);
    repeat (T - 1) @(negedge clk);
    chk("timeout_not_yet", 32'({bus.busy, bus.err_led}), 32'b10);
    @(negedge clk);
    chk("timeout_err", 32'(bus.err_led), 1);
    wait_idle("timeout");
    // duplicate of slot0 written into slot3
    pulse(5'b11100, 3);
    pulse(5'b11001, 0);
    pulse(5'b11001, 0);
    wait_idle("dup");
`ifdef PWPROG_DUP_CHECK_EN
    chk("dup_slot3", 32'(bus.tbl_flat[19:15]), 32'(5'b11100));
`else
    chk("dup_slot3", 32'(bus.tbl_flat[19:15]), 32'(5'b11001));
`endif
    // asynchronous reset mid-sequence restores defaults
    pulse(5'b11001, 0);
    pulse(5'b00101, 0);
    #3 rst_n = 0;
    #1;
    chk("async_rst_tbl", 32'(bus.tbl_flat), 32'(20'b11100_01010_10111_11001));
    chk("async_rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/password_programmer.md
# password_programmer

Sequential enrolment block for the 5-bit switch password lock. It owns the 4-slot password table, presented flat so the combinational checker can compare against it. It lets an operator replace one slot's code with a new one, using this sequence:
- authenticate with the slot's current code;
- enter the new code;
- confirm the new code.

It sits between the debounced switch/button front end and the password checker.

## Interface
- `CODE_W`, 5, password width (SW1..SW5, SW1 = bit 0)
- `N_SLOTS`, 4, table entries (slot index width = 2)
- `TIMEOUT_CYC`, 250_000_000, idle cycles allowed in NEW1/NEW2 before abort (5 s at 50 MHz)
- `HOLD_CYC`, 100_000_000, cycles DONE/ERR indication is held (2 s at 50 MHz)

Ports (clock and reset first):
- `clk`  in  1  system clock, single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `code_in`  in  5  switch code {SW5..SW1}, sampled only on `enter`
- `slot_sel`  in  2  target slot, sampled only on the authenticating `enter`
- `enter`  in  1  single-cycle pulse from the upstream debouncer
- `prog_en`  in  1  programming enable (SW8 role); low forces IDLE
- `tbl_flat`  out  20  slot k at bits [5k+4:5k], registered
- `busy`  out  1  high in every state except IDLE
- `done_led`  out  1  high while in DONE
- `err_led`  out  1  high while in ERR

## Operation
- Reset values of `tbl_flat`:
  - slot0 = 5'b11001
  - slot1 = 5'b10111
  - slot2 = 5'b01010
  - slot3 = 5'b11100
- Reset values of all other state: state = IDLE, `busy` = `done_led` = `err_led` = 0, counters = 0.
- States: IDLE, NEW1, NEW2, COMMIT, DONE, ERR.
- IDLE, on `enter` while `prog_en`=1:
  - latch `slot_sel` into `slot_q`;
  - if `code_in` == table[`slot_sel`], go to NEW1, else go to ERR.
  - `enter` while `prog_en`=0 is ignored.
- NEW1, on `enter`: latch `code_in` into `new_q`, go to NEW2.
- NEW2, on `enter`:
  - if `code_in` == `new_q` (and passes the duplicate check, see Configuration), go to COMMIT;
  - otherwise go to ERR.
- COMMIT: lasts exactly one cycle. table[`slot_q`] <= `new_q`, then go to DONE. Other slots are unchanged.
- DONE / ERR:
  - hold for HOLD_CYC cycles, then go to IDLE;
  - `enter` is ignored while in these states.
- Timeout:
  - the wait counter clears on entry to NEW1/NEW2 and on every `enter`;
  - reaching TIMEOUT_CYC-1 without an `enter` goes to ERR.
- `prog_en` falling in any non-IDLE state:
  - next state is IDLE, with no table write, even from COMMIT;
  - `new_q` is discarded;
  - this takes priority over `enter` and timeout in the same cycle.
- New code equal to the slot's old code is accepted (a rewrite with no change).
- Hold and timeout counters are sized ceil(log2(max(TIMEOUT_CYC, HOLD_CYC))). They saturate, never wrap.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- State transitions:
  - `enter` high at edge t → new state (and `busy`/LEDs) visible after edge t.
  - Authenticating `enter` at t → NEW1 at t+1.
  - Confirming `enter` at t → COMMIT at t+1, DONE at t+2, updated `tbl_flat` at t+2.
- Comparisons in IDLE use the current `tbl_flat`; a write and a compare never overlap.
- `rst_n` low mid-sequence:
  - immediate asynchronous return to reset values;
  - the table reverts to its defaults.

## Configuration
- `PWPROG_DUP_CHECK_EN`
  - Defined: in NEW2, `new_q` matching any slot other than `slot_q` goes to ERR, so no two slots hold the same code.
  - Undefined: duplicates are allowed, and only the confirm-match is checked.

## Structure
- Shared package `password_pkg`:
  - `CODE_W` and `N_SLOTS` constants;
  - the four default-code constants (shared with the checker);
  - the state enum type.
- One natural sub-module: `pw_hold_timer`, a loadable saturating down-counter with a `load` input and an `expired` output, used for both the timeout and the hold.

## Test plan
- Default table check: after reset, `tbl_flat` = {11100,01010,10111,11001}, `busy`=0.
- Happy path:
  - slot_sel=2, enter 01010, then 00111, then 00111;
  - required: COMMIT one cycle, slot2 = 00111, `done_led`=1 for HOLD_CYC cycles, then IDLE.
- Bad auth: slot_sel=0, enter 00000 → ERR, `err_led`=1, table unchanged.
- Confirm mismatch: auth slot1 with 10111, new 00001, confirm 00010 → ERR, slot1 still 10111.
- Abort paths:
  - `prog_en` dropped in NEW2 → IDLE next cycle, no write;
  - no `enter` for TIMEOUT_CYC in NEW1 (bench uses small parameters) → ERR.
- Duplicate check, with `PWPROG_DUP_CHECK_EN` defined:
  - slot3, new code 11001 twice → ERR;
  - with the macro undefined, the same sequence → slot3 = 11001.
